aes_key_expand: RTL and testbench

- Round-key generator directly upstream of the AES encrypt core.
- Expands a 128/192/256-bit cipher key into 11/13/15 round keys (FIPS-197 KeyExpansion), producing one 32-bit word per cycle into internal storage.
- Serves round keys to the encrypt core on a combinational address/valid interface.
- Streams: a round key is valid as soon as its four words exist, so encryption may overlap expansion.

---
 rtl/aes_pkg.sv | 57 +++++
 rtl/aes_sub_word.sv | 14 +
 rtl/aes_key_expand.sv | 171 +++++++++++++++++
 tb/tb_aes_key_expand.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: key-length encodings, key-schedule sizes, xtime and the S-box.
package aes_pkg;

    localparam int unsigned KEY_LEN_W = 3;

    localparam logic [KEY_LEN_W-1:0] KEY_LEN_128 = 3'b001;
    localparam logic [KEY_LEN_W-1:0] KEY_LEN_192 = 3'b010;
    localparam logic [KEY_LEN_W-1:0] KEY_LEN_256 = 3'b100;

    localparam int unsigned NK_128 = 4;
    localparam int unsigned NK_192 = 6;
    localparam int unsigned NK_256 = 8;

    localparam int unsigned ROUND_KEYS_128 = 11;
    localparam int unsigned ROUND_KEYS_192 = 13;
    localparam int unsigned ROUND_KEYS_256 = 15;

    localparam int unsigned WORDS_128 = 4 * ROUND_KEYS_128;
    localparam int unsigned WORDS_192 = 4 * ROUND_KEYS_192;
    localparam int unsigned WORDS_256 = 4 * ROUND_KEYS_256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_DONE
    } ke_state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Single-byte S-box lookup
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub_c
);

    // Four parallel byte substitutions
    always_comb begin
        sub_c = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
    end

endmodule

// File: rtl/aes_key_expand.sv
// AES key expansion: one schedule word per cycle into local storage, round keys
// served combinationally as soon as their four words exist.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 60
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [255:0]         key_in,
    input  logic [KEY_LEN_W-1:0] key_len,
    input  logic                 key_start,
    output logic                 busy,
    output logic                 key_ready,
    input  logic [3:0]           subkey_addr,
    output logic [127:0]         subkey,
    output logic                 subkey_valid
);

    localparam int unsigned WC_W  = 6;
    localparam int unsigned NK_W  = 4;
    localparam int unsigned MOD_W = 3;

    ke_state_t         state_q, state_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [WC_W-1:0]   total_q, total_d;
    logic [NK_W-1:0]   nk_q, nk_d;
    logic [MOD_W-1:0]  mod_q, mod_d;
    logic [7:0]        rcon_q, rcon_d;
    logic              busy_d, key_ready_d;
    logic              load_key, write_word;

    logic [31:0]       w_q [MAX_WORDS];
    logic [7:0][31:0]  key_w;

    logic [NK_W-1:0]   nk_dec;
    logic [WC_W-1:0]   total_dec;
    logic              start_ok;

    logic [31:0]       prev_word, back_word, sub_in, sub_out, temp, new_word;
    logic [WC_W-1:0]   base;

    assign key_w = key_in;

    // Key size decode, largest size wins when several bits are set
    always_comb begin
        nk_dec    = '0;
        total_dec = '0;
        if ((key_len & KEY_LEN_256) != '0) begin
            nk_dec    = NK_W'(NK_256);
            total_dec = WC_W'(WORDS_256);
        end else if ((key_len & KEY_LEN_192) != '0) begin
            nk_dec    = NK_W'(NK_192);
            total_dec = WC_W'(WORDS_192);
        end else if ((key_len & KEY_LEN_128) != '0) begin
            nk_dec    = NK_W'(NK_128);
            total_dec = WC_W'(WORDS_128);
        end
    end

    assign start_ok = key_start && (key_len != '0) && (state_q != ST_EXPAND);

    // Next schedule word from w[i-1] and w[i-Nk]
    always_comb begin
        prev_word = w_q[wc_q - WC_W'(1)];
        back_word = w_q[wc_q - WC_W'(nk_q)];
        sub_in    = (mod_q == '0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        temp      = prev_word;
        if (mod_q == '0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if ((nk_q == NK_W'(NK_256)) && (mod_q == MOD_W'(4))) begin
            temp = sub_out;
        end
        new_word = back_word ^ temp;
    end

    aes_sub_word u_sub_word (
        .word  (sub_in),
        .sub_c (sub_out)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        total_d     = total_q;
        nk_d        = nk_q;
        mod_d       = mod_q;
        rcon_d      = rcon_q;
        busy_d      = busy;
        key_ready_d = key_ready;
        load_key    = 1'b0;
        write_word  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    load_key    = 1'b1;
                    state_d     = ST_EXPAND;
                    nk_d        = nk_dec;
                    total_d     = total_dec;
                    wc_d        = WC_W'(nk_dec);
                    mod_d       = '0;
                    rcon_d      = 8'h01;
                    busy_d      = 1'b1;
                    key_ready_d = 1'b0;
                end
            end
            ST_EXPAND: begin
                write_word = 1'b1;
                wc_d       = wc_q + WC_W'(1);
                mod_d      = (mod_q == MOD_W'(nk_q - NK_W'(1))) ? '0 : mod_q + MOD_W'(1);
                if (mod_q == '0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (wc_q == total_q - WC_W'(1)) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    key_ready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wc_q      <= '0;
            total_q   <= '0;
            nk_q      <= '0;
            mod_q     <= '0;
            rcon_q    <= '0;
            busy      <= 1'b0;
            key_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            wc_q      <= wc_d;
            total_q   <= total_d;
            nk_q      <= nk_d;
            mod_q     <= mod_d;
            rcon_q    <= rcon_d;
            busy      <= busy_d;
            key_ready <= key_ready_d;
        end
    end

    // Word storage: Nk key words on start, then one expanded word per cycle
    always_ff @(posedge clk) begin
        if (load_key) begin
            for (int unsigned k = 0; k < 8; k++) begin
                if (NK_W'(k) < nk_dec) begin
                    w_q[WC_W'(k)] <= key_w[3'(7 - k)];
                end
            end
        end else if (write_word) begin
            w_q[wc_q] <= new_word;
        end
    end

    // Round-key read port, zero unless all four words are present
    always_comb begin
        base         = {subkey_addr, 2'b00};
        subkey_valid = subkey_addr < wc_q[WC_W-1:2];
        subkey       = '0;
        if (subkey_valid) begin
            subkey = {w_q[base], w_q[base + WC_W'(1)], w_q[base + WC_W'(2)], w_q[base + WC_W'(3)]};
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors plus a cycle model of word production.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] key_in = '0;
    logic [2:0]   key_len = '0;
    logic         key_start = 1'b0;
    logic         busy, key_ready;
    logic [3:0]   subkey_addr = '0;
    logic [127:0] subkey;
    logic         subkey_valid;

    always #5 clk = ~clk;

    aes_key_expand dut (
        .clk          (clk),
        .reset        (reset),
        .key_in       (key_in),
        .key_len      (key_len),
        .key_start    (key_start),
        .busy         (busy),
        .key_ready    (key_ready),
        .subkey_addr  (subkey_addr),
        .subkey       (subkey),
        .subkey_valid (subkey_valid)
    );

    localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  sb [256];
    logic [31:0] m_words [64];
    int          m_wc = 0;
    int          m_total = 0;
    int          m_nk = 0;
    bit          m_busy = 1'b0;
    bit          m_ready = 1'b0;
    bit          cmp_en = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv, xb, yb;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                yb = 8'(y);
                if (gmul(xb, yb) == 8'h01) inv = yb;
            end
            sb[xb] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // Full key schedule computed at once, straight from the textbook recurrence
    task automatic expand(input logic [255:0] key, input int nk);
        logic [7:0][31:0] kw;
        logic [31:0] t;
        logic [7:0]  rc;
        kw = key;
        for (int i = 0; i < nk; i++) m_words[6'(i)] = kw[3'(7 - i)];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = m_words[6'(i - 1)];
            if (i % nk == 0) begin
                t  = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_w(t);
            end
            m_words[6'(i)] = m_words[6'(i - nk)] ^ t;
        end
    endtask

    // Cycle model: how many schedule words exist after each edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_wc    <= 0;
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
        end else if (m_busy) begin
            m_wc <= m_wc + 1;
            if (m_wc + 1 == m_total) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
            end
        end else if (key_start && key_len != 3'b000) begin
            m_nk = key_len[2] ? 8 : (key_len[1] ? 6 : 4);
            expand(key_in, m_nk);
            m_wc    <= m_nk;
            m_total <= 4 * (m_nk + 7);
            m_busy  <= 1'b1;
            m_ready <= 1'b0;
        end
    end

    logic         exp_v;
    logic [127:0] exp_k;
    int           a4;

    // Compare DUT against the model every cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            a4    = 4 * int'(subkey_addr);
            exp_v = int'(subkey_addr) < (m_wc / 4);
            exp_k = exp_v ? {m_words[6'(a4)], m_words[6'(a4 + 1)], m_words[6'(a4 + 2)], m_words[6'(a4 + 3)]} : 128'h0;
            check("model_busy", 128'(busy), 128'(m_busy));
            check("model_key_ready", 128'(key_ready), 128'(m_ready));
            check("model_subkey_valid", 128'(subkey_valid), 128'(exp_v));
            check("model_subkey", subkey, exp_k);
        end
    end

    task automatic start_key(input logic [255:0] k, input logic [2:0] len);
        @(posedge clk);
        #2;
        key_in    = k;
        key_len   = len;
        key_start = 1'b1;
        @(posedge clk);
        #2;
        key_start = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (key_ready) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic read_check(input string name, input logic [3:0] addr,
                              input logic ev, input logic [127:0] ek);
        @(posedge clk);
        #1;
        subkey_addr = addr;
        #1;
        check({name, "_valid"}, 128'(subkey_valid), 128'(ev));
        check({name, "_key"}, subkey, ek);
    endtask

    int n;

    initial begin
        build_sbox();
        #1;
        reset  = 1'b0;
        cmp_en = 1'b1;
        #2;
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_key_ready", 128'(key_ready), 128'(0));
        check("reset_subkey_valid", 128'(subkey_valid), 128'(0));
        check("reset_subkey", subkey, 128'h0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;

        // key_len of zero is ignored in IDLE
        start_key(KEY_A1, 3'b000);
        #1;
        check("len0_idle_busy", 128'(busy), 128'(0));

        // AES-128
        start_key(KEY_A1, 3'b001);
        wait_ready(n);
        check("a1_latency", 128'(n), 128'(40));
        read_check("a1_addr10", 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_check("a1_addr11", 4'd11, 1'b0, 128'h0);
        read_check("a1_addr0", 4'd0, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        read_check("a1_addr1", 4'd1, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605);

        // key_len of zero is ignored in DONE
        subkey_addr = 4'd10;
        start_key(KEY_A3, 3'b000);
        #1;
        check("len0_done_ready", 128'(key_ready), 128'(1));
        check("len0_done_key", subkey, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Restart from DONE with AES-192
        subkey_addr = 4'd1;
        start_key(KEY_A2, 3'b010);
        #1;
        check("restart_ready_drop", 128'(key_ready), 128'(0));
        check("restart_addr1_drop", 128'(subkey_valid), 128'(0));
        wait_ready(n);
        check("a2_latency", 128'(n), 128'(46));
        @(posedge clk);
        #1;
        subkey_addr = 4'd12;
        #1;
        check("a2_addr12_low", 128'(subkey[31:0]), 128'(32'h01002202));
        read_check("a2_addr13", 4'd13, 1'b0, 128'h0);

        // AES-256
        start_key(KEY_A3, 3'b100);
        wait_ready(n);
        check("a3_latency", 128'(n), 128'(52));
        @(posedge clk);
        #1;
        subkey_addr = 4'd14;
        #1;
        check("a3_addr14_low", 128'(subkey[31:0]), 128'(32'h706c631e));
        read_check("a3_addr0", 4'd0, 1'b1, 128'h603deb1015ca71be2b73aef0857d7781);
        read_check("a3_addr15", 4'd15, 1'b0, 128'h0);

        // Streaming: round key 2 appears once word 11 is written
        subkey_addr = 4'd2;
        start_key(KEY_A1, 3'b001);
        n = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (subkey_valid) begin
                n = c;
                break;
            end
        end
        check("stream_addr2_cycles", 128'(n), 128'(8));
        subkey_addr = 4'd3;
        #1;
        check("stream_addr3_low", 128'(subkey_valid), 128'(0));
        subkey_addr = 4'd2;
        wait_ready(n);

        // key_start during EXPAND is ignored
        start_key(KEY_A1, 3'b001);
        repeat (9) @(posedge clk);
        #2;
        key_in    = KEY_A3;
        key_len   = 3'b100;
        key_start = 1'b1;
        @(posedge clk);
        #2;
        key_start = 1'b0;
        wait_ready(n);
        check("ignore_latency", 128'(n), 128'(30));
        read_check("ignore_addr10", 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Asynchronous reset mid-expansion, then a clean AES-128 run
        subkey_addr = 4'd0;
        start_key(KEY_A1, 3'b001);
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_busy", 128'(busy), 128'(0));
        check("midreset_key_ready", 128'(key_ready), 128'(0));
        check("midreset_subkey_valid", 128'(subkey_valid), 128'(0));
        @(posedge clk);
        #2;
        reset = 1'b1;
        start_key(KEY_A1, 3'b001);
        wait_ready(n);
        check("after_reset_latency", 128'(n), 128'(40));
        read_check("after_reset_addr10", 4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_check("after_reset_addr1", 4'd1, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605);

        repeat (2) @(posedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
